// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter that time-shares the LED bank among N_REQ requesters.
// Each grant latches its pattern and holds it for DWELL prescaled ticks.
module led_bank_arbiter #(
  parameter int unsigned      N_REQ        = 4,
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      PRESCALE     = 262144,
  parameter int unsigned      DWELL        = 4,
  parameter logic [WIDTH-1:0] IDLE_PATTERN = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] pattern,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       leds,
  output logic                   busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]   leds_q, leds_d;
  logic               busy_q, busy_d;
  logic [PS_W-1:0]    presc_q, presc_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;

  logic               tick;
  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;

  assign tick = (presc_q == PS_W'(PRESCALE - 1));

  // Round-robin search starting just after the last owner, wrapping around.
  // Descending loop so the nearest candidate is the final assignment.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      int unsigned cand;
      cand = (32'(last_q) + k) % N_REQ;
      if (req[IDX_W'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    leds_d  = leds_q;
    busy_d  = busy_q;
    presc_d = tick ? '0 : presc_q + PS_W'(1);
    dwell_d = dwell_q;
    last_d  = last_q;
    owner_d = owner_q;

    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        leds_d  = IDLE_PATTERN;
        if (arb_found) begin
          state_d = ST_SHOW;
          grant_d = N_REQ'(1) << arb_idx;
          busy_d  = 1'b1;
          leds_d  = pattern[32'(arb_idx) * WIDTH +: WIDTH];
          owner_d = arb_idx;
          presc_d = '0;
          dwell_d = '0;
        end
      end

      ST_SHOW: begin
        // A dropped request aborts the dwell and wins over completion.
        if (!req[owner_q] || (tick && (dwell_q == DW_W'(DWELL - 1)))) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          leds_d  = IDLE_PATTERN;
          last_d  = owner_q;
          dwell_d = '0;
          if (req[owner_q]) begin
            done_d[owner_q] = 1'b1;
          end
        end else if (tick) begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      leds_q  <= IDLE_PATTERN;
      busy_q  <= 1'b0;
      presc_q <= '0;
      dwell_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign leds  = leds_q;
  assign busy  = busy_q;

endmodule

// File: doc/led_bank_arbiter.md
# led_bank_arbiter

Time-shares the board's 8-LED output bank among up to N_REQ requesters. Each requester presents a pattern and a request. The arbiter grants the bank round-robin and holds each pattern on the LEDs for a fixed dwell time, counted in prescaled ticks derived from the board clock. It sits between the user logic and the LED output buffers, replacing direct counter-to-LED wiring.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- WIDTH, 8: LED bank width.
- PRESCALE, 262144: clock cycles per tick, ≥2.
- DWELL, 4: ticks each grant holds the bank, ≥1.
- IDLE_PATTERN, 8'h00: LED value when no grant is active (WIDTH bits).

Ports:
- clk  in  1  board clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- req  in  N_REQ  level request per requester.
- pattern  in  N_REQ*WIDTH  requester i's pattern at bits [i*WIDTH +: WIDTH].
- grant  out  N_REQ  one-hot (or zero) current owner.
- done  out  N_REQ  one-cycle pulse when owner i completes its full dwell.
- leds  out  WIDTH  registered LED drive.
- busy  out  1  high while in SHOW.

## Operation
- States: IDLE and SHOW.
- Reset values:
  - state = IDLE; grant = 0; done = 0; busy = 0.
  - leds = IDLE_PATTERN; prescale counter = 0; dwell counter = 0.
  - Round-robin pointer `last` = N_REQ-1, so requester 0 wins first.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - `tick` is high when the count equals PRESCALE-1.
  - Cleared to 0 on every IDLE→SHOW transition, so each dwell lasts exactly DWELL*PRESCALE cycles.
- IDLE:
  - If any req bit is set, select the first set bit searching (last+1) mod N_REQ upward with wrap. Call it g.
  - Next cycle: state = SHOW, grant = 1<<g, busy = 1, leds = pattern[g] as sampled this cycle.
  - The latched pattern is held for the whole dwell. Later changes to pattern inputs are ignored.
  - If no req bit is set, stay in IDLE with leds = IDLE_PATTERN.
- SHOW:
  - The dwell counter increments on each tick.
  - Normal completion: tick occurs with dwell count == DWELL-1. Next cycle:
    - done[g] = 1 for exactly one cycle;
    - grant = 0, busy = 0, leds = IDLE_PATTERN, last = g, state = IDLE.
  - Abort: req[g] is low in any SHOW cycle. Next cycle:
    - return to IDLE exactly as above, but with no done pulse;
    - last = g, so the aborted requester loses its turn.
  - Abort takes priority over completion when both occur in the same cycle.
- Requests to non-owners during SHOW are ignored until the next IDLE arbitration. They are not queued or lost; req is a level signal.
- Any rst cycle forces reset values next cycle, including mid-SHOW. No done pulse is emitted on reset.

## Timing
- Grant latency:
  - req rises in cycle t while in IDLE → grant, busy and leds valid in cycle t+1.
- Dwell:
  - grant is high in cycles t+1 .. t+DWELL*PRESCALE inclusive.
  - done pulse and grant drop occur in cycle t+1+DWELL*PRESCALE.
- Back-to-back grants:
  - The arbitration cycle is the IDLE cycle in which done is high.
  - The next grant appears in the following cycle, so at least one cycle of IDLE_PATTERN separates consecutive owners.
- Abort:
  - req[g] low in cycle a → grant low and leds = IDLE_PATTERN in cycle a+1.
- Outputs are registered; there is no combinational path from req or pattern to any output.

## Test plan
Bench parameters: N_REQ=4, PRESCALE=4, DWELL=2, so one dwell = 8 cycles.

1. Reset state: hold rst for 3 cycles with req=4'hF → grant=0, busy=0, leds=8'h00, done=0 throughout. After release, grant=4'b0001 one cycle later.
2. Single requester: req[2]=1 with pattern[2]=8'hA5 from cycle 10 → grant=4'b0100 and leds=8'hA5 for cycles 11–18; done[2] pulses in cycle 19, where leds=8'h00. Changing pattern[2] to 8'h3C at cycle 14 leaves leds at 8'hA5.
3. Round-robin: req=4'b1011 held continuously → grant order is 0,1,3,0. Each grant lasts 8 cycles, separated by exactly one idle cycle, with one done pulse per grant.
4. Abort: grant requester 1, then drop req[1] in the 3rd SHOW cycle → grant=0 next cycle, no done pulse, and the next grant goes to requester 2 if req[2] is set.
5. Reset mid-SHOW: assert rst in the 5th SHOW cycle → next cycle all outputs are at reset values, no done pulse, and the pointer restarts so requester 0 wins first.
6. Prescaler realignment: issue a request while the free-running prescaler is mid-count → dwell is still exactly 8 cycles.
